seg_scan_driver: RTL and testbench

- Time-multiplexed driver for the board's 4-digit common-anode seven-segment display.
- Sits directly downstream of the pattern-generating stages, such as the segment-chase animator. It takes four 8-bit active-low segment patterns and scans them onto the shared `out` and `anode` pins.
- Double-buffers pattern updates so that a new frame only takes effect on a frame boundary, which prevents tearing.
- Inserts a blanking gap between digits to suppress ghosting.

---
 rtl/seg_scan_driver.sv | 94 +++++++++
 tb/tb_seg_scan_driver.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_driver.sv
// Four-digit common-anode seven-segment scan driver with frame-aligned
// double buffering and a per-slot blanking gap to suppress ghosting.
module seg_scan_driver #(
  parameter int unsigned CLK_DIV      = 50000,
  parameter int unsigned BLANK_CYCLES = 4
) (
  input  logic        input_clock,
  input  logic        rst_n,
  input  logic        load,
  input  logic [31:0] digit_data,
  input  logic [3:0]  digit_en,
  output logic [7:0]  out,
  output logic [3:0]  anode,
  output logic        pending,
  output logic        frame_done
);

  localparam int unsigned CNT_W = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_idx;
  logic [31:0]      r_active;
  logic [31:0]      r_shadow;
  logic [3:0]       r_act_en;
  logic [3:0]       r_sh_en;

  logic             w_slot_end;
  logic             w_boundary;
  logic             w_show;
  logic [7:0]       w_pattern;

  always_comb begin
    w_slot_end = (r_cnt == CNT_LAST);
    w_boundary = w_slot_end && (r_idx == 2'd3);
    w_show     = (32'(r_cnt) >= BLANK_CYCLES) && r_act_en[r_idx];
    w_pattern  = r_active[{r_idx, 3'b000} +: 8];
  end

  always_ff @(posedge input_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
      r_idx <= '0;
    end else if (w_slot_end) begin
      r_cnt <= '0;
      r_idx <= r_idx + 2'd1;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Activation reads the pre-edge shadow, so a load on the boundary edge
  // is held back and applied one frame later.
  always_ff @(posedge input_clock or negedge rst_n) begin
    if (!rst_n) begin
      r_active <= '1;
      r_act_en <= '0;
      r_shadow <= '1;
      r_sh_en  <= '0;
      pending  <= 1'b0;
    end else begin
      if (w_boundary && pending) begin
        r_active <= r_shadow;
        r_act_en <= r_sh_en;
      end
      if (load) begin
        r_shadow <= digit_data;
        r_sh_en  <= digit_en;
        pending  <= 1'b1;
      end else if (w_boundary) begin
        pending  <= 1'b0;
      end
    end
  end

  // Outputs reflect the counter phase of the previous cycle for every digit.
  always_ff @(posedge input_clock or negedge rst_n) begin
    if (!rst_n) begin
      out        <= '1;
      anode      <= '1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= w_boundary;
      if (w_show) begin
        out   <= w_pattern;
        anode <= ~(4'b0001 << r_idx);
      end else begin
        out   <= '1;
        anode <= '1;
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_driver.sv
// Randomised bench for seg_scan_driver: a frame-position model predicts every
// output each cycle, with directed scenarios pinning the model to literals.
module tb_seg_scan_driver;

  localparam int unsigned CLK_DIV = 8;
  localparam int unsigned BLANK   = 2;
  localparam int unsigned FRAME   = 4 * CLK_DIV;

  logic        clk;
  logic        rst_n;
  logic        load;
  logic [31:0] digit_data;
  logic [3:0]  digit_en;
  logic [7:0]  out;
  logic [3:0]  anode;
  logic        pending;
  logic        frame_done;

  int n_tests = 0;
  int n_fail  = 0;

  seg_scan_driver #(.CLK_DIV(CLK_DIV), .BLANK_CYCLES(BLANK)) dut (
    .input_clock(clk),
    .rst_n      (rst_n),
    .load       (load),
    .digit_data (digit_data),
    .digit_en   (digit_en),
    .out        (out),
    .anode      (anode),
    .pending    (pending),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: position within the frame (pre-edge), byte arrays for the buffers.
  int unsigned m_pos;
  logic [7:0]  m_act [4];
  logic [7:0]  m_sh  [4];
  logic [3:0]  m_act_en, m_sh_en;
  logic        m_pend;
  logic [7:0]  e_out;
  logic [3:0]  e_an;
  logic        e_fd, e_pend;
  int unsigned disp_pos;

  assign disp_pos = (m_pos + FRAME - 1) % FRAME;

  always @(posedge clk or negedge rst_n) begin : model
    int unsigned p, d, c;
    if (!rst_n) begin
      m_pos    <= 0;
      m_act_en <= 4'h0;
      m_sh_en  <= 4'h0;
      m_pend   <= 1'b0;
      for (int k = 0; k < 4; k++) begin
        m_act[k] <= 8'hFF;
        m_sh[k]  <= 8'hFF;
      end
      e_out  <= 8'hFF;
      e_an   <= 4'hF;
      e_fd   <= 1'b0;
      e_pend <= 1'b0;
    end else begin
      p = m_pos;
      d = p / CLK_DIV;
      c = p % CLK_DIV;
      if (c < BLANK || !m_act_en[d]) begin
        e_out <= 8'hFF;
        e_an  <= 4'hF;
      end else begin
        e_out <= m_act[d];
        e_an  <= 4'hF ^ (4'b0001 << d);
      end
      e_fd <= (p == FRAME - 1);
      if (p == FRAME - 1 && m_pend) begin
        m_act_en <= m_sh_en;
        for (int k = 0; k < 4; k++) m_act[k] <= m_sh[k];
      end
      if (load) begin
        m_sh_en <= digit_en;
        for (int k = 0; k < 4; k++) m_sh[k] <= digit_data[8*k +: 8];
        m_pend <= 1'b1;
        e_pend <= 1'b1;
      end else if (p == FRAME - 1) begin
        m_pend <= 1'b0;
        e_pend <= 1'b0;
      end else begin
        e_pend <= m_pend;
      end
      m_pos <= (p + 1) % FRAME;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    chk("out", {24'h0, out}, {24'h0, e_out});
    chk("anode", {28'h0, anode}, {28'h0, e_an});
    chk("pending", {31'h0, pending}, {31'h0, e_pend});
    chk("frame_done", {31'h0, frame_done}, {31'h0, e_fd});
  end

  task automatic wait_disp(input int unsigned target);
    bit hit = 1'b0;
    for (int i = 0; i < 2 * FRAME + 2; i++) begin
      @(negedge clk);
      if (disp_pos == target) begin
        hit = 1'b1;
        break;
      end
    end
    if (!hit) begin
      n_tests++;
      n_fail++;
      $display("FAIL wait_disp: position %0d not reached, got %0d", target, disp_pos);
    end
  endtask

  task automatic do_load(input logic [31:0] data, input logic [3:0] en);
    load       = 1'b1;
    digit_data = data;
    digit_en   = en;
    @(negedge clk);
    load       = 1'b0;
    digit_data = $urandom;
    digit_en   = 4'($urandom);
  endtask

  logic [31:0] pat_a, pat_b, pat_c;

  initial begin
    rst_n      = 1'b0;
    load       = 1'b0;
    digit_data = '0;
    digit_en   = '0;
    repeat (3) @(negedge clk);
    chk("reset_out", {24'h0, out}, 32'h0000_00FF);
    chk("reset_anode", {28'h0, anode}, 32'h0000_000F);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);

    // Basic scan
    wait_disp(5);
    do_load(32'h92B0_A4F9, 4'hF);
    chk("basic_pend_set", {31'h0, pending}, 32'd1);
    wait_disp(31);
    chk("basic_pend_clr", {31'h0, pending}, 32'd0);
    wait_disp(1);
    chk("basic_blank_an", {28'h0, anode}, 32'hF);
    chk("basic_blank_out", {24'h0, out}, 32'hFF);
    wait_disp(2);
    chk("basic_d0", {20'h0, anode, out}, 32'hE_F9);
    wait_disp(10);
    chk("basic_d1", {20'h0, anode, out}, 32'hD_A4);
    wait_disp(18);
    chk("basic_d2", {20'h0, anode, out}, 32'hB_B0);
    wait_disp(31);
    chk("basic_d3", {20'h0, anode, out}, 32'h7_92);
    chk("basic_fd", {31'h0, frame_done}, 32'd1);

    // Disabled digits
    wait_disp(5);
    do_load(32'h1234_5678, 4'b0101);
    wait_disp(31);
    wait_disp(12);
    chk("dis_d1", {20'h0, anode, out}, 32'hF_FF);
    wait_disp(20);
    chk("dis_d2", {20'h0, anode, out}, 32'hB_34);

    // Tearing: two loads during digit 1, last wins
    pat_a = $urandom;
    pat_b = $urandom;
    wait_disp(9);
    do_load(pat_a, 4'hF);
    @(negedge clk);
    do_load(pat_b, 4'hF);
    wait_disp(20);
    chk("tear_old", {20'h0, anode, out}, 32'hB_34);
    wait_disp(30);
    chk("tear_pend_hold", {31'h0, pending}, 32'd1);
    wait_disp(31);
    chk("tear_pend_clr", {31'h0, pending}, 32'd0);
    wait_disp(2);
    chk("tear_new", {20'h0, anode, out}, {20'h0, 4'hE, pat_b[7:0]});

    // Load exactly on the boundary edge with nothing pending
    pat_c = $urandom;
    wait_disp(30);
    chk("bnd_pend_pre", {31'h0, pending}, 32'd0);
    do_load(pat_c, 4'hF);
    chk("bnd_pend_post", {31'h0, pending}, 32'd1);
    wait_disp(2);
    chk("bnd_unchanged", {20'h0, anode, out}, {20'h0, 4'hE, pat_b[7:0]});
    wait_disp(30);
    chk("bnd_pend_frame", {31'h0, pending}, 32'd1);
    wait_disp(31);
    chk("bnd_pend_clr", {31'h0, pending}, 32'd0);
    wait_disp(2);
    chk("bnd_applied", {20'h0, anode, out}, {20'h0, 4'hE, pat_c[7:0]});

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        do_load($urandom, 4'($urandom_range(0, 15)));
      end else begin
        @(negedge clk);
      end
    end

    // Reset mid-slot with a pending load
    wait_disp(3);
    do_load($urandom, 4'hF);
    wait_disp(20);
    chk("rst_pre_pend", {31'h0, pending}, 32'd1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_async_out", {24'h0, out}, 32'hFF);
    chk("rst_async_an", {28'h0, anode}, 32'hF);
    chk("rst_async_pend", {31'h0, pending}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rst_restart_blank", {20'h0, anode, out}, 32'hF_FF);
    repeat (70) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1);
  end

endmodule
